img_seq_ctrl: RTL and testbench
===============================

IMG_SEQ_CTRL -- requirements
Module: img_seq_ctrl

Interface
REQ-001 Parameter IMG_BYTES, 113: bytes per image frame.
REQ-002 Parameter TIMEOUT_CYCLES, 1000000: stall limit in LOAD (after first byte) and WAIT_INFER.
REQ-003 Parameter RES_W, 4: inference result width.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rx_data  in  8  incoming image byte.
REQ-007 rx_valid / rx_ready  in / out  1 each  byte handshake.
REQ-008 buf_data  out  8  byte to image buffer.
REQ-009 buf_write_request  out  1  buffer write strobe.
REQ-010 buf_write_ready / buf_full  in  1 each  buffer status; buf_full lags the final write by one cycle.
REQ-011 buf_clear  out  1  buffer clear pulse.
REQ-012 infer_start  out  1  one-cycle inference start pulse.
REQ-013 infer_done  in  1  inference complete strobe.
REQ-014 infer_result  in  RES_W  class, valid with infer_done.
REQ-015 res_data  out  RES_W; res_valid  out  1; res_ready  in  1  result handshake.
REQ-016 abort  in  1  synchronous abort request.
REQ-017 busy  out  1; err_timeout  out  1; state_dbg  out  3  status.

Function
REQ-018 States: CLEAR(0), LOAD(1), WAIT_FULL(2), START(3), WAIT_INFER(4), REPORT(5); state_dbg equals the encoding.
REQ-019 CLEAR lasts exactly one cycle, drives buf_clear=1, zeroes byte and stall counters, then enters LOAD.
REQ-020 In LOAD, rx_ready = buf_write_ready; everywhere else rx_ready = 0.
REQ-021 buf_write_request = rx_valid && rx_ready (combinational); buf_data = rx_data; zero added latency.
REQ-022 Byte counter (7 bits) increments per accepted byte; the accept making the count IMG_BYTES moves LOAD->WAIT_FULL on the next edge.
REQ-023 WAIT_FULL holds until buf_full=1, then enters START.
REQ-024 START asserts infer_start for exactly one cycle, then enters WAIT_INFER.
REQ-025 In WAIT_INFER, infer_done=1 registers infer_result into res_data and enters REPORT.
REQ-026 In REPORT, res_valid=1 and res_data holds stable until res_ready=1; that handshake cycle moves to CLEAR. res_ready sampled in the first REPORT cycle completes the transfer in that cycle.
REQ-027 Stall counter resets on every accepted byte and on state entry, counts each idle cycle in LOAD (byte count>0) and in WAIT_INFER; on reaching TIMEOUT_CYCLES it sets err_timeout and forces CLEAR.
REQ-028 err_timeout is sticky; it clears on the first byte accepted afterwards.
REQ-029 abort=1 forces CLEAR on the next edge from any state, with priority over infer_done, res_ready, timeout and byte accept; any result in flight is discarded and res_valid drops.
REQ-030 infer_done outside WAIT_INFER is ignored.
REQ-031 busy = 1 in every state except LOAD with byte count 0.
REQ-032 Byte counter saturates at IMG_BYTES; no wrap.

Reset
REQ-033 rst_n low asynchronously forces state CLEAR, counters 0, res_data 0, res_valid 0, infer_start 0, err_timeout 0.
REQ-034 The first cycle after reset release is CLEAR, so buf_clear pulses once.
REQ-035 Reset mid-frame discards all progress; no output toggles while rst_n is low except buf_clear=1.

Structure
REQ-036 Shared package ocr_pkg holds the state enum, IMG_BYTES and RES_W.
REQ-037 One sub-module, stall_timer (load/clear/expire), implements REQ-027; everything else is flat.

Verification
REQ-038 Reset release, stream 113 bytes back-to-back, buf_full one cycle later -> exactly one infer_start, 113 write strobes, no extra write.
REQ-039 infer_done with infer_result=7, res_ready held low 5 cycles -> res_valid high 5+ cycles, res_data=7 stable, then CLEAR pulse and LOAD.
REQ-040 TIMEOUT_CYCLES=16, send 10 bytes then stop -> err_timeout=1 on cycle 16 of idle, buf_clear pulse, byte count 0; next byte clears err_timeout.
REQ-041 abort same cycle as infer_done -> no res_valid, CLEAR next cycle.
REQ-042 buf_write_ready=0 during LOAD with rx_valid=1 -> rx_ready=0, no write, count unchanged.
REQ-043 rst_n asserted at byte 50 -> outputs reset immediately; after release, a full 113-byte frame completes normally.

Source files
------------

// File: rtl/ocr_pkg.sv
// Shared types and defaults for the image-sequencing controller.
package ocr_pkg;

  localparam int unsigned IMG_BYTES      = 113;
  localparam int unsigned RES_W          = 4;
  localparam int unsigned TIMEOUT_CYCLES = 1000000;
  localparam int unsigned BYTE_CNT_W     = 7;
  localparam int unsigned STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_CLEAR      = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_FULL  = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT_INFER = 3'd4,
    ST_REPORT     = 3'd5
  } state_e;

  // Saturating byte-count increment; never wraps past lim.
  function automatic logic [BYTE_CNT_W-1:0] byte_cnt_inc(
    input logic [BYTE_CNT_W-1:0] cnt,
    input logic [BYTE_CNT_W-1:0] lim
  );
    return (cnt >= lim) ? cnt : cnt + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Idle-cycle watchdog: counts ticks, restarts on clear, flags the tick that hits LIMIT.
module stall_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is a function of the tick alone so it never feeds back through clear_i.
  assign expire_c = tick_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/img_seq_ctrl.sv
// Frame sequencer: clears the image buffer, loads one frame of bytes, runs
// inference and hands the class result downstream, with stall timeout and abort.
module img_seq_ctrl #(
  parameter int unsigned IMG_BYTES      = ocr_pkg::IMG_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = ocr_pkg::TIMEOUT_CYCLES,
  parameter int unsigned RES_W          = ocr_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       buf_data,
  output logic             buf_write_request,
  input  logic             buf_write_ready,
  input  logic             buf_full,
  output logic             buf_clear,
  output logic             infer_start,
  input  logic             infer_done,
  input  logic [RES_W-1:0] infer_result,
  output logic [RES_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  input  logic             abort,
  output logic             busy,
  output logic             err_timeout,
  output logic [2:0]       state_dbg
);

  import ocr_pkg::*;

  localparam logic [BYTE_CNT_W-1:0] FRAME_LEN = BYTE_CNT_W'(IMG_BYTES);

  state_e                 state_q, state_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [RES_W-1:0]       res_data_q, res_data_d;
  logic                   err_q, err_d;
  logic                   accept_c;
  logic                   stall_tick_c;
  logic                   stall_clear_c;
  logic                   stall_expire_c;

  // Byte path is a straight pass-through gated only by buffer readiness in LOAD.
  assign rx_ready          = (state_q == ST_LOAD) && buf_write_ready;
  assign accept_c          = rx_valid && rx_ready;
  assign buf_write_request = accept_c;
  assign buf_data          = rx_data;

  // Idle cycles count only once a frame has started, or while inference runs.
  assign stall_tick_c  = ((state_q == ST_LOAD) && (byte_cnt_q != '0) && !accept_c) ||
                         ((state_q == ST_WAIT_INFER) && !infer_done);
  assign stall_clear_c = accept_c ||
                         !((state_q == ST_LOAD) || (state_q == ST_WAIT_INFER));

  stall_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (stall_clear_c),
    .tick_i   (stall_tick_c),
    .expire_c (stall_expire_c)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    res_data_d = res_data_q;
    err_d      = err_q;

    if (accept_c) begin
      byte_cnt_d = byte_cnt_inc(byte_cnt_q, FRAME_LEN);
      err_d      = 1'b0;
    end

    case (state_q)
      ST_CLEAR: begin
        byte_cnt_d = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (stall_expire_c) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else if (accept_c && (byte_cnt_d == FRAME_LEN)) begin
          state_d = ST_WAIT_FULL;
        end
      end
      ST_WAIT_FULL: begin
        if (buf_full) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_INFER;
      end
      ST_WAIT_INFER: begin
        if (infer_done) begin
          res_data_d = infer_result;
          state_d    = ST_REPORT;
        end else if (stall_expire_c) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Abort wins over every other event and leaves result/error untouched.
    if (abort) begin
      state_d    = ST_CLEAR;
      res_data_d = res_data_q;
      err_d      = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      byte_cnt_q <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  assign buf_clear   = (state_q == ST_CLEAR);
  assign infer_start = (state_q == ST_START);
  assign res_valid   = (state_q == ST_REPORT);
  assign res_data    = res_data_q;
  assign err_timeout = err_q;
  assign busy        = !((state_q == ST_LOAD) && (byte_cnt_q == '0));
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_img_seq_ctrl.sv
// Directed bench for img_seq_ctrl: frame load, result handshake, timeout, abort, reset.
module tb_img_seq_ctrl;

  localparam int unsigned RES_W = 4;

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       buf_data;
  logic             buf_write_request;
  logic             buf_write_ready;
  logic             buf_full;
  logic             buf_clear;
  logic             infer_start;
  logic             infer_done;
  logic [RES_W-1:0] infer_result;
  logic [RES_W-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             abort;
  logic             busy;
  logic             err_timeout;
  logic [2:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_start  = 0;
  int wr_base;
  int start_base;

  img_seq_ctrl #(
    .IMG_BYTES      (113),
    .TIMEOUT_CYCLES (16),
    .RES_W          (RES_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .buf_data          (buf_data),
    .buf_write_request (buf_write_request),
    .buf_write_ready   (buf_write_ready),
    .buf_full          (buf_full),
    .buf_clear         (buf_clear),
    .infer_start       (infer_start),
    .infer_done        (infer_done),
    .infer_result      (infer_result),
    .res_data          (res_data),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .abort             (abort),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .state_dbg         (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && buf_write_request) n_wr <= n_wr + 1;
    if (rst_n && infer_start)       n_start <= n_start + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'(i + 1);
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame_to_infer();
    stream(113);
    buf_full = 1'b1;
    @(negedge clk);
    buf_full = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    rx_data         = 8'h00;
    rx_valid        = 1'b0;
    buf_write_ready = 1'b1;
    buf_full        = 1'b0;
    infer_done      = 1'b0;
    infer_result    = '0;
    res_ready       = 1'b0;
    abort           = 1'b0;

    // Reset state
    #12;
    chk("rst_state",       32'(state_dbg),   32'd0);
    chk("rst_buf_clear",   32'(buf_clear),   32'd1);
    chk("rst_res_valid",   32'(res_valid),   32'd0);
    chk("rst_infer_start", 32'(infer_start), 32'd0);
    chk("rst_err",         32'(err_timeout), 32'd0);
    chk("rst_res_data",    32'(res_data),    32'd0);
    chk("rst_rx_ready",    32'(rx_ready),    32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_clear_cycle", 32'(buf_clear), 32'd1);
    @(negedge clk);
    chk("rel_load_state", 32'(state_dbg), 32'd1);
    chk("rel_idle_busy",  32'(busy),      32'd0);
    chk("rel_rx_ready",   32'(rx_ready),  32'd1);

    // Full frame back-to-back
    wr_base    = n_wr;
    start_base = n_start;
    stream(113);
    chk("frame_wait_full", 32'(state_dbg), 32'd2);
    chk("frame_writes",    32'(n_wr - wr_base), 32'd113);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    #1;
    chk("wf_rx_ready",  32'(rx_ready),          32'd0);
    chk("wf_no_write",  32'(buf_write_request), 32'd0);
    chk("wf_buf_data",  32'(buf_data),          32'hA5);
    buf_full = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    buf_full = 1'b0;
    chk("start_state", 32'(state_dbg),   32'd3);
    chk("start_pulse", 32'(infer_start), 32'd1);
    @(negedge clk);
    chk("winf_state",     32'(state_dbg),          32'd4);
    chk("winf_no_start",  32'(infer_start),        32'd0);
    chk("frame_writes2",  32'(n_wr - wr_base),     32'd113);
    chk("frame_starts",   32'(n_start - start_base), 32'd1);

    // Result held while downstream stalls
    infer_done   = 1'b1;
    infer_result = 4'd7;
    @(negedge clk);
    infer_done   = 1'b0;
    infer_result = 4'd0;
    chk("rep_state", 32'(state_dbg), 32'd5);
    chk("rep_valid", 32'(res_valid), 32'd1);
    chk("rep_data",  32'(res_data),  32'd7);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("rep_hold_valid", 32'(res_valid), 32'd1);
    chk("rep_hold_data",  32'(res_data),  32'd7);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rep_done_clear",  32'(state_dbg), 32'd0);
    chk("rep_done_bclr",   32'(buf_clear), 32'd1);
    chk("rep_done_rvalid", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("rep_back_load", 32'(state_dbg), 32'd1);
    chk("rep_starts",    32'(n_start - start_base), 32'd1);

    // Buffer not ready blocks the byte path
    buf_write_ready = 1'b0;
    rx_valid        = 1'b1;
    wr_base         = n_wr;
    #1;
    chk("bwr_rx_ready", 32'(rx_ready),          32'd0);
    chk("bwr_no_write", 32'(buf_write_request), 32'd0);
    @(negedge clk);
    chk("bwr_count_same", 32'(busy),            32'd0);
    chk("bwr_writes",     32'(n_wr - wr_base),  32'd0);
    buf_write_ready = 1'b1;
    rx_valid        = 1'b0;

    // Stall timeout after 10 bytes
    stream(10);
    for (int j = 2; j <= 16; j++) @(negedge clk);
    chk("to_pre_state", 32'(state_dbg),   32'd1);
    chk("to_pre_err",   32'(err_timeout), 32'd0);
    chk("to_pre_busy",  32'(busy),        32'd1);
    @(negedge clk);
    chk("to_clear",     32'(state_dbg),   32'd0);
    chk("to_bclr",      32'(buf_clear),   32'd1);
    chk("to_err",       32'(err_timeout), 32'd1);
    @(negedge clk);
    chk("to_load",      32'(state_dbg),   32'd1);
    chk("to_cnt_zero",  32'(busy),        32'd0);
    chk("to_err_stick", 32'(err_timeout), 32'd1);
    stream(1);
    chk("to_err_clr",   32'(err_timeout), 32'd0);
    chk("to_busy_1b",   32'(busy),        32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_clr", 32'(state_dbg), 32'd0);
    @(negedge clk);
    chk("abort_load_idle", 32'(busy), 32'd0);

    // Abort coincident with infer_done
    frame_to_infer();
    chk("ab_winf", 32'(state_dbg), 32'd4);
    infer_done   = 1'b1;
    infer_result = 4'd9;
    abort        = 1'b1;
    @(negedge clk);
    infer_done   = 1'b0;
    abort        = 1'b0;
    chk("ab_clear",  32'(state_dbg), 32'd0);
    chk("ab_rvalid", 32'(res_valid), 32'd0);
    chk("ab_rdata",  32'(res_data),  32'd7);
    @(negedge clk);
    chk("ab_load",    32'(state_dbg), 32'd1);
    chk("ab_rvalid2", 32'(res_valid), 32'd0);

    // Stray infer_done in LOAD
    infer_done = 1'b1;
    @(negedge clk);
    infer_done = 1'b0;
    chk("stray_state",  32'(state_dbg), 32'd1);
    chk("stray_rvalid", 32'(res_valid), 32'd0);

    // Reset mid-frame, then a clean frame with immediate result accept
    stream(50);
    chk("mid_busy", 32'(busy), 32'd1);
    rx_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state",  32'(state_dbg),         32'd0);
    chk("mid_rst_bclr",   32'(buf_clear),         32'd1);
    chk("mid_rst_rdata",  32'(res_data),          32'd0);
    chk("mid_rst_rvalid", 32'(res_valid),         32'd0);
    chk("mid_rst_start",  32'(infer_start),       32'd0);
    chk("mid_rst_err",    32'(err_timeout),       32'd0);
    chk("mid_rst_wr",     32'(buf_write_request), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_load", 32'(state_dbg), 32'd1);
    chk("post_rst_idle", 32'(busy),      32'd0);
    wr_base    = n_wr;
    start_base = n_start;
    frame_to_infer();
    chk("pr_winf", 32'(state_dbg), 32'd4);
    infer_done   = 1'b1;
    infer_result = 4'd3;
    res_ready    = 1'b1;
    @(negedge clk);
    infer_done = 1'b0;
    chk("pr_rep_state", 32'(state_dbg), 32'd5);
    chk("pr_rep_valid", 32'(res_valid), 32'd1);
    chk("pr_rep_data",  32'(res_data),  32'd3);
    @(negedge clk);
    res_ready = 1'b0;
    chk("pr_fast_clear", 32'(state_dbg), 32'd0);
    chk("pr_writes",     32'(n_wr - wr_base),       32'd113);
    chk("pr_starts",     32'(n_start - start_base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
